// File: rtl/demux4_deser_pkg.sv
// demux4_deser_pkg: shared constants, channel index type and one-hot helper
// for the 4-channel demux deserializer.
package demux4_deser_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t ch);
    logic [NUM_CH-1:0] v;
    v     = 4'b0000;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux4_lane_asm.sv
// demux4_lane_asm: one channel of the deserializer. Shift-assembles bits,
// parks completed words in a holding register and flags overflow when a new
// word completes while the previous one is still parked and not being drained.
// Optional feature macro: DEMUX4_DESER_PARITY_EN (trailing even-parity bit).
module demux4_lane_asm
  import demux4_deser_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en_i,
  input  logic              bit_i,
  input  logic              grant_i,
  output logic [WORD_W-1:0] hold_o,
`ifdef DEMUX4_DESER_PARITY_EN
  output logic              perr_o,
`endif
  output logic              full_o,
  output logic              ovf_o
);

`ifdef DEMUX4_DESER_PARITY_EN
  localparam int NBITS = WORD_W + 1;
`else
  localparam int NBITS = WORD_W;
`endif
  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] shifted_s, word_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              done_s;
`ifdef DEMUX4_DESER_PARITY_EN
  logic              perr_q, perr_d;
`endif

  // Shift the incoming bit in and decide what a completing word looks like.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {shreg_q[WORD_W-2:0], bit_i};
    end else begin
      shifted_s = {bit_i, shreg_q[WORD_W-1:1]};
    end
`ifdef DEMUX4_DESER_PARITY_EN
    // The final bit is parity only; the data bits are already in the shifter.
    word_s = shreg_q;
`else
    word_s = shifted_s;
`endif
    done_s = bit_en_i && (cnt_q == CNT_LAST);
  end

  // Next-state for shifter, counter, hold slot and sticky overflow.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
`ifdef DEMUX4_DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    // A grant empties the slot; a same-cycle completion refills it below.
    if (grant_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (bit_en_i) begin
      shreg_d = shifted_s;
      if (done_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      shreg_d = shreg_q;
    end
    if (done_s) begin
      if (full_q && !grant_i) begin
        // Old word still parked and not leaving: drop the new one.
        ovf_d = 1'b1;
      end else begin
        hold_d = word_s;
        full_d = 1'b1;
`ifdef DEMUX4_DESER_PARITY_EN
        perr_d = (^word_s) ^ bit_i;
`endif
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= {WORD_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      hold_q  <= {WORD_W{1'b0}};
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DEMUX4_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
`ifdef DEMUX4_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign hold_o = hold_q;
  assign full_o = full_q;
  assign ovf_o  = ovf_q;
`ifdef DEMUX4_DESER_PARITY_EN
  assign perr_o = perr_q;
`endif

endmodule

// File: rtl/demux4_chan_deser.sv
// demux4_chan_deser: rebuilds tagged parallel words from the serial stream
// behind a 1-to-4 demux. Four assembly lanes feed a round-robin registered
// ready/valid output port. Optional feature macro: DEMUX4_DESER_PARITY_EN
// (adds out_perr).
module demux4_chan_deser
  import demux4_deser_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic [1:0]        sel,
  input  logic [3:0]        y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_chan,
`ifdef DEMUX4_DESER_PARITY_EN
  output logic              out_perr,
`endif
  output logic              proto_err,
  output logic [3:0]        ovf
);

  logic [WORD_W-1:0] hold_s [NUM_CH];
  logic [NUM_CH-1:0] full_s, ovf_s, bit_en_s, grant_s, sel_oh_s;
  logic              bit_s, load_s, found_s, proto_err_d;
  ch_idx_t           gnt_idx_s, cand_s;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  ch_idx_t           out_chan_q, out_chan_d;
  ch_idx_t           rr_q, rr_d;
  logic              proto_err_q;
`ifdef DEMUX4_DESER_PARITY_EN
  logic [NUM_CH-1:0] perr_s;
  logic              out_perr_q, out_perr_d;
`endif

  assign sel_oh_s = onehot4(sel);
  assign bit_s    = y[sel];
  assign bit_en_s = {NUM_CH{bit_valid}} & sel_oh_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    demux4_lane_asm #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .bit_en_i (bit_en_s[gi]),
      .bit_i    (bit_s),
      .grant_i  (grant_s[gi]),
      .hold_o   (hold_s[gi]),
`ifdef DEMUX4_DESER_PARITY_EN
      .perr_o   (perr_s[gi]),
`endif
      .full_o   (full_s[gi]),
      .ovf_o    (ovf_s[gi])
    );
  end

  // Round-robin pick of the first full lane at or after rr when the port frees.
  always_comb begin
    load_s    = (!out_valid_q || out_ready) && (|full_s);
    gnt_idx_s = rr_q;
    found_s   = 1'b0;
    cand_s    = rr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = rr_q + ch_idx_t'(i);
      if (!found_s && full_s[cand_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (load_s) begin
      grant_s = onehot4(gnt_idx_s);
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Output port next-state: load a granted word, or retire the accepted one.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_d        = rr_q;
`ifdef DEMUX4_DESER_PARITY_EN
    out_perr_d  = out_perr_q;
`endif
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = hold_s[gnt_idx_s];
      out_chan_d  = gnt_idx_s;
      rr_d        = gnt_idx_s + 2'd1;
`ifdef DEMUX4_DESER_PARITY_EN
      out_perr_d  = perr_s[gnt_idx_s];
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // Any active y line other than the selected one is a demux fault.
    proto_err_d = bit_valid && ((y & ~sel_oh_s) != 4'b0000);
  end

  // Output port and protocol-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WORD_W{1'b0}};
      out_chan_q  <= 2'd0;
      rr_q        <= 2'd0;
      proto_err_q <= 1'b0;
`ifdef DEMUX4_DESER_PARITY_EN
      out_perr_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_q        <= rr_d;
      proto_err_q <= proto_err_d;
`ifdef DEMUX4_DESER_PARITY_EN
      out_perr_q  <= out_perr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign proto_err = proto_err_q;
  assign ovf       = ovf_s;
`ifdef DEMUX4_DESER_PARITY_EN
  assign out_perr  = out_perr_q;
`endif

endmodule
